// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush arbiter: load-use stalls, EX redirects, trap drain
// sequencing and saturating stall/flush performance counters.
module hazard_flush_ctrl #(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_is_jump,
  input  logic                  exception,
  input  logic                  mem_busy,
  output logic                  pc_stall,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [1:0]            pc_sel,
  output logic                  in_drain,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int unsigned          DRAIN_W    = 4;
  localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] FRONT_MASK = NUM_STAGES'(3);
  localparam logic [NUM_STAGES-1:0] EX_MASK    = NUM_STAGES'(4);
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_REDIR = 2'd1;
  localparam logic [1:0] PC_TRAP  = 2'd2;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic                 lu, redir, flush_evt;

  // Hazard detection; x0 never creates a dependency
  always_comb begin
    lu = ex_mem_read && (ex_rd != '0) &&
         ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    redir = ex_branch_taken || ex_is_jump;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next state and prioritised stall/flush outputs
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pc_stall      = 1'b0;
    stall         = '0;
    flush         = '0;
    pc_sel        = PC_SEQ;
    in_drain      = 1'b0;
    flush_evt     = 1'b0;
    case (state)
      RUN: begin
        if (exception) begin
          flush         = '1;
          pc_sel        = PC_TRAP;
          flush_evt     = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end else if (mem_busy) begin
          stall    = '1;
          pc_stall = 1'b1;
        end else if (redir) begin
          flush     = FRONT_MASK;
          pc_sel    = PC_REDIR;
          flush_evt = 1'b1;
        end else if (lu) begin
          pc_stall = 1'b1;
          stall    = FRONT_MASK;
          flush    = EX_MASK;
        end
      end
      DRAIN: begin
        flush    = '1;
        pc_stall = 1'b1;
        in_drain = 1'b1;
        if (drain_cnt == '0) state_nxt = RUN;
        else drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && (flush_events != CNT_MAX)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
Sequential pipeline hazard and flush controller for the rv32 core. It sits alongside the decode control unit and arbitrates stall and flush requests across all pipeline stages. Requests come from load-use hazards, EX-resolved branches and jumps (jal/jalr), exceptions and multi-cycle memory waits. It adds a trap-drain state machine and saturating performance counters, and is parametrised in stage count, register-address width, drain length and counter width.

Parameters:
NUM_STAGES, 5, pipeline stage count; bit index 0=IF, 1=ID, 2=EX, 3..NUM_STAGES-1 = back-end stages; legal range >=4.
REG_ADDR_W, 5, register specifier width.
DRAIN_CYCLES, 2, cycles spent in DRAIN after an accepted exception; legal range 1..15.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
id_rs1  input  REG_ADDR_W  rs1 specifier of the instruction in ID.
id_rs2  input  REG_ADDR_W  rs2 specifier of the instruction in ID.
id_uses_rs1  input  1  ID instruction reads rs1.
id_uses_rs2  input  1  ID instruction reads rs2.
ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
ex_mem_read  input  1  instruction in EX is a load.
ex_branch_taken  input  1  branch resolved taken in EX.
ex_is_jump  input  1  jal/jalr in EX.
exception  input  1  exception raised by any stage this cycle.
mem_busy  input  1  data memory is not ready; the back end must hold.
pc_stall  output  1  hold the PC.
stall  output  NUM_STAGES  per-stage hold (pipeline register keeps its value).
flush  output  NUM_STAGES  per-stage bubble insert (pipeline register is cleared to a NOP).
pc_sel  output  2  PC source: 0 = sequential, 1 = EX redirect target, 2 = trap vector.
in_drain  output  1  high while in DRAIN.
stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1.
flush_events  output  CNT_W  saturating count of accepted redirects plus accepted exceptions.

Behaviour:
- Reset (async, rst=1): state=RUN, drain counter=0, both perf counters=0. Outputs are combinational from state and inputs, so with inputs low they are all 0. Reset asserted mid-DRAIN returns to RUN immediately.
- Load-use hazard: lu = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Redirect: redir = ex_branch_taken | ex_is_jump.
- RUN-state priority, highest first (only one row applies per cycle):
  1. exception: flush=all ones, stall=0, pc_stall=0, pc_sel=2. Next state DRAIN, drain counter loaded with DRAIN_CYCLES-1. flush_events +1.
  2. mem_busy: stall=all ones, flush=0, pc_stall=1, pc_sel=0. Redirect and load-use are not acted on; they re-evaluate on a later cycle because EX is held.
  3. redir: flush[0]=flush[1]=1, all else 0, pc_sel=1, pc_stall=0. flush_events +1. Load-use in the same cycle is ignored because the ID instruction is squashed.
  4. lu: pc_stall=1, stall[0]=stall[1]=1, flush[2]=1 (EX bubble), pc_sel=0. Lasts exactly one cycle because the load advances to MEM.
  5. None of the above: all outputs 0.
- DRAIN state:
  - Outputs: flush=all ones, pc_stall=1, stall=0, pc_sel=0, in_drain=1.
  - exception, redir, lu and mem_busy are all ignored; they are not counted and not queued.
  - Counter decrements each cycle; DRAIN->RUN on the cycle the counter equals 0. Total DRAIN residency is exactly DRAIN_CYCLES cycles.
- stall and flush are never both set on the same stage bit.
- Counters:
  - stall_cycles increments on every clock edge where pc_stall=1, including DRAIN cycles.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - A cycle that would increment a counter already at max leaves it unchanged.

Test Plan:
- Reset: assert rst mid-DRAIN with DRAIN_CYCLES=2 -> in_drain=0 and both counters=0 without waiting for a clock edge; all outputs 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_stall=1, stall=5'b00011, flush=5'b00100, stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Redirect plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition also true -> flush=5'b00011, stall=0, pc_sel=1, flush_events=1.
- Exception then DRAIN: exception pulse -> cycle 0 flush=5'b11111 and pc_sel=2; next 2 cycles in_drain=1 with pc_stall=1; a second exception during DRAIN is ignored; back to RUN on the 4th cycle; flush_events=1, stall_cycles=2.
- mem_busy with a pending redirect: mem_busy=1 for 3 cycles while ex_is_jump=1 -> stall=5'b11111, flush=0 for 3 cycles; on the cycle mem_busy drops, flush=5'b00011 and pc_sel=1.
- Saturation: CNT_W=4, hold the load-use condition for 20 cycles -> stall_cycles stops at 15 and does not wrap.
